// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM channel-1 arbiter.
// Holds the FSM state encoding and the per-requester request bundle.
package sdram_arb_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/sdram_ch1_arbiter_rr_pick.sv
// Cyclic first-set search over pending bits 1..N-1, starting at i_ptr.
// Bit 0 is never considered; it has its own priority path.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_pend,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N - 1; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N - 1);
            end
            if (!o_valid && i_pend[w_sum[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_ch1_arbiter.sv
// Arbiter sharing SDRAM channel 1: requester 0 has priority with a
// starvation cap, the rest are served round-robin, one transaction at a time.
module sdram_ch1_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              rq_req,
    input  logic [NUM_REQ-1:0]              rq_rnw,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  rq_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  rq_din,
    input  logic [NUM_REQ-1:0][BE_W-1:0]    rq_be,
    output logic [NUM_REQ-1:0]              rq_done,
    output logic                            rq_err,
    output logic [DATA_W-1:0]               rq_dout,
    output logic                            mem_req,
    output logic                            mem_rnw,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_din,
    output logic [BE_W-1:0]                 mem_be,
    input  logic                            mem_ready,
    input  logic [DATA_W-1:0]               mem_dout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int KW = $clog2(MAX_CONSEC + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_pending;
    logic [IW-1:0]       r_ptr;
    logic [KW-1:0]       r_consec;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_gnt;
    logic                r_err;
    logic [DATA_W-1:0]   r_dout;
    logic                r_mem_req;
    mem_req_t            r_mem;

    logic [IW-1:0]       w_rr_idx;
    logic                w_rr_valid;
    logic                w_others;
    logic                w_cap;
    logic                w_pick0;
    logic                w_grant;
    logic [IW-1:0]       w_g;
    logic [NUM_REQ-1:0]  w_gmask;
    logic                w_tmo;
    mem_req_t            w_sel;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_pend  (r_pending),
        .i_ptr   (r_ptr),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    // Requester 0 wins unless it has hit its consecutive-grant cap
    // while someone else is waiting.
    assign w_others = |r_pending[NUM_REQ-1:1];
    assign w_cap    = (r_consec == KW'(MAX_CONSEC)) && w_others;
    assign w_pick0  = r_pending[0] && !w_cap;
    assign w_grant  = (r_state == IDLE) && (w_pick0 || w_rr_valid);
    assign w_g      = w_pick0 ? '0 : w_rr_idx;
    assign w_gmask  = w_grant ? (NUM_REQ'(1) << w_g) : '0;
    assign w_tmo    = (r_cnt == CW'(TIMEOUT));

    always_comb begin
        w_sel.rnw  = rq_rnw[w_g];
        w_sel.addr = rq_addr[w_g];
        w_sel.din  = rq_din[w_g];
        w_sel.be   = rq_rnw[w_g] ? '1 : rq_be[w_g];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_grant) w_state_nxt = WAIT;
            WAIT: if (mem_ready || w_tmo) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rq_done = '0;
        rq_err  = 1'b0;
        if (r_state == DONE) begin
            rq_done[r_gnt] = 1'b1;
            rq_err         = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_ptr     <= IW'(1);
            r_consec  <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_err     <= 1'b0;
            r_dout    <= '0;
            r_mem_req <= 1'b0;
            r_mem     <= '0;
        end else begin
            // A request landing on its own grant edge is a fresh request.
            r_pending <= (r_pending & ~w_gmask) | rq_req;
            r_mem_req <= w_grant;
            if (w_grant) begin
                r_mem <= w_sel;
                r_gnt <= w_g;
                r_cnt <= '0;
                if (w_g == '0 && w_others) begin
                    if (r_consec != KW'(MAX_CONSEC)) begin
                        r_consec <= r_consec + 1'b1;
                    end
                end else begin
                    r_consec <= '0;
                end
                if (w_g != '0) begin
                    r_ptr <= (w_g == IW'(NUM_REQ - 1)) ? IW'(1) : w_g + 1'b1;
                end
            end
            if (r_state == WAIT) begin
                if (mem_ready) begin
                    r_dout <= mem_dout;
                    r_err  <= 1'b0;
                end else if (w_tmo) begin
                    r_dout <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_rnw  = r_mem.rnw;
    assign mem_addr = r_mem.addr;
    assign mem_din  = r_mem.din;
    assign mem_be   = r_mem.be;
    assign rq_dout  = r_dout;

endmodule

// File: tb/tb_sdram_ch1_arbiter.sv
// Self-checking bench for sdram_ch1_arbiter: scoreboard of expected
// grants and completions, plus per-scenario timing checks.
module tb_sdram_ch1_arbiter;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         rq_req;
    logic [N-1:0]         rq_rnw;
    logic [N-1:0][26:0]   rq_addr;
    logic [N-1:0][31:0]   rq_din;
    logic [N-1:0][3:0]    rq_be;
    logic [N-1:0]         rq_done;
    logic                 rq_err;
    logic [31:0]          rq_dout;
    logic                 mem_req;
    logic                 mem_rnw;
    logic [26:0]          mem_addr;
    logic [31:0]          mem_din;
    logic [3:0]           mem_be;
    logic                 mem_ready;
    logic [31:0]          mem_dout;

    sdram_ch1_arbiter #(
        .NUM_REQ    (N),
        .MAX_CONSEC (4),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rq_req    (rq_req),
        .rq_rnw    (rq_rnw),
        .rq_addr   (rq_addr),
        .rq_din    (rq_din),
        .rq_be     (rq_be),
        .rq_done   (rq_done),
        .rq_err    (rq_err),
        .rq_dout   (rq_dout),
        .mem_req   (mem_req),
        .mem_rnw   (mem_rnw),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rnw;
        logic [26:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
    } xreq_t;

    typedef struct {
        logic [3:0]  done;
        logic        err;
        logic [31:0] dout;
    } xdone_t;

    xreq_t  exp_req[$];
    xdone_t exp_done[$];

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;
    int n_req, n_done, n_resp;
    int req_cyc, ready_cyc, done_cyc;
    logic [31:0] rbase;

    // Expected downstream request and completion for a grant to g.
    task automatic exp_push(input int g, input logic err, input logic [31:0] dout);
        xreq_t  r;
        xdone_t d;
        r.rnw  = rq_rnw[g];
        r.addr = rq_addr[g];
        r.din  = rq_din[g];
        r.be   = rq_rnw[g] ? 4'hF : rq_be[g];
        d.done = 4'(1 << g);
        d.err  = err;
        d.dout = dout;
        exp_req.push_back(r);
        exp_done.push_back(d);
    endtask

    // Drives requests and the memory side for ncyc cycles; scoreboards outputs.
    task automatic service(input logic [3:0] mask, input int hold, input int ncyc,
                           input int lat, input bit respond, input int rereq0);
        int     cnt;
        int     left;
        xreq_t  e;
        xdone_t d;
        cnt       = 0;
        left      = rereq0;
        n_req     = 0;
        n_done    = 0;
        req_cyc   = -1;
        ready_cyc = -1;
        done_cyc  = -1;
        rq_req    = mask;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            rq_req    = (i + 1 < hold) ? mask : '0;
            mem_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = rbase + 32'(n_resp);
                    n_resp++;
                    ready_cyc = cyc;
                end
            end
            if (mem_req === 1'b1) begin
                n_req++;
                req_cyc = cyc;
                if (respond) cnt = lat;
                tests_run++;
                if (exp_req.size() == 0) begin
                    fails++;
                    $display("FAIL sb_req: unexpected mem_req addr=%h", mem_addr);
                end else begin
                    e = exp_req.pop_front();
                    if ({mem_rnw, mem_addr, mem_din, mem_be} !== {e.rnw, e.addr, e.din, e.be}) begin
                        fails++;
                        $display("FAIL sb_req: got rnw=%b addr=%h din=%h be=%h, want rnw=%b addr=%h din=%h be=%h",
                                 mem_rnw, mem_addr, mem_din, mem_be, e.rnw, e.addr, e.din, e.be);
                    end
                end
            end
            if (rq_done !== 4'b0) begin
                n_done++;
                done_cyc = cyc;
                tests_run++;
                if (exp_done.size() == 0) begin
                    fails++;
                    $display("FAIL sb_done: unexpected rq_done=%b", rq_done);
                end else begin
                    d = exp_done.pop_front();
                    if ({rq_done, rq_err, rq_dout} !== {d.done, d.err, d.dout}) begin
                        fails++;
                        $display("FAIL sb_done: got done=%b err=%b dout=%h, want done=%b err=%b dout=%h",
                                 rq_done, rq_err, rq_dout, d.done, d.err, d.dout);
                    end
                end
                if (rq_done[0] && left > 0) begin
                    rq_req[0] = 1'b1;
                    left--;
                end
            end
        end
        rq_req    = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        rq_req    = '0;
        mem_ready = 1'b0;
        exp_req.delete();
        exp_done.delete();
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b1;
        n_resp  = 0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        rq_req    = 4'b0010;
        @(negedge clk);
        cyc++;
        rq_req = '0;
        @(negedge clk);
        cyc++;
        tests_run++;
        if ({mem_req, mem_rnw, mem_addr, mem_din, mem_be, rq_done, rq_err, rq_dout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: mem_req=%b addr=%h done=%b err=%b dout=%h, want all 0",
                     mem_req, mem_addr, rq_done, rq_err, rq_dout);
        end
        reset_n = 1'b1;
        service(4'b0000, 1, 6, 1, 1'b1, 0);
        tests_run++;
        if (n_req != 0) begin
            fails++;
            $display("FAIL reset_pending: mem_req count %0d, want 0", n_req);
        end
    endtask

    task automatic test_single_read();
        int k;
        do_reset();
        rq_rnw[2]  = 1'b1;
        rq_addr[2] = 27'h0001000;
        rq_be[2]   = 4'h0;
        rbase      = 32'hDEADBEEF;
        exp_push(2, 1'b0, 32'hDEADBEEF);
        k = cyc;
        service(4'b0100, 1, 20, 6, 1'b1, 0);
        tests_run++;
        if (req_cyc != k + 2) begin
            fails++;
            $display("FAIL read_issue_lat: mem_req at %0d, want %0d", req_cyc, k + 2);
        end
        tests_run++;
        if (n_req != 1 || n_done != 1) begin
            fails++;
            $display("FAIL read_counts: req=%0d done=%0d, want 1 1", n_req, n_done);
        end
        tests_run++;
        if (done_cyc != ready_cyc + 1) begin
            fails++;
            $display("FAIL read_done_lat: done at %0d, want %0d", done_cyc, ready_cyc + 1);
        end
        tests_run++;
        if (rq_dout !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL read_dout_hold: rq_dout=%h, want deadbeef", rq_dout);
        end
    endtask

    task automatic test_write();
        do_reset();
        rq_rnw[1]  = 1'b0;
        rq_addr[1] = 27'h4000040;
        rq_din[1]  = 32'h12345678;
        rq_be[1]   = 4'b0011;
        rbase      = 32'h0BADF00D;
        exp_push(1, 1'b0, 32'h0BADF00D);
        service(4'b0010, 1, 15, 3, 1'b1, 0);
        tests_run++;
        if (n_done != 1 || done_cyc != ready_cyc + 1) begin
            fails++;
            $display("FAIL write_done: count=%0d at %0d, want 1 at %0d", n_done, done_cyc, ready_cyc + 1);
        end
        rq_rnw[1] = 1'b1;
    endtask

    task automatic test_round_robin();
        do_reset();
        rbase = 32'h100;
        exp_push(1, 1'b0, 32'h100);
        exp_push(2, 1'b0, 32'h101);
        exp_push(3, 1'b0, 32'h102);
        service(4'b1110, 1, 30, 2, 1'b1, 0);
        tests_run++;
        if (n_done != 3 || exp_req.size() != 0) begin
            fails++;
            $display("FAIL rr_first: done=%0d left=%0d, want 3 0", n_done, exp_req.size());
        end
        rbase  = 32'h200;
        n_resp = 0;
        exp_push(1, 1'b0, 32'h200);
        exp_push(3, 1'b0, 32'h201);
        service(4'b1010, 1, 20, 2, 1'b1, 0);
        tests_run++;
        if (n_done != 2 || exp_req.size() != 0) begin
            fails++;
            $display("FAIL rr_wrap: done=%0d left=%0d, want 2 0", n_done, exp_req.size());
        end
    endtask

    task automatic test_starvation();
        int order[6];
        order = '{0, 0, 0, 0, 3, 0};
        do_reset();
        rbase = 32'h300;
        for (int i = 0; i < 6; i++) begin
            exp_push(order[i], 1'b0, 32'h300 + 32'(i));
        end
        service(4'b1001, 1, 50, 1, 1'b1, 4);
        tests_run++;
        if (n_done != 6 || exp_done.size() != 0) begin
            fails++;
            $display("FAIL starve_cap: done=%0d left=%0d, want 6 0", n_done, exp_done.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rbase = 32'h55AA55AA;
        exp_push(1, 1'b0, 32'h55AA55AA);
        service(4'b0010, 1, 10, 1, 1'b1, 0);
        exp_push(2, 1'b1, 32'h0);
        service(4'b0100, 1, 25, 1, 1'b0, 0);
        tests_run++;
        if (n_done != 1 || done_cyc != req_cyc + TMO + 1) begin
            fails++;
            $display("FAIL timeout_lat: done=%0d at %0d, want 1 at %0d", n_done, done_cyc, req_cyc + TMO + 1);
        end
        mem_ready = 1'b1;
        mem_dout  = 32'hFFFFFFFF;
        @(negedge clk);
        cyc++;
        mem_ready = 1'b0;
        service(4'b0000, 1, 6, 1, 1'b0, 0);
        tests_run++;
        if (n_done != 0 || rq_dout !== 32'h0) begin
            fails++;
            $display("FAIL late_ready: done=%0d dout=%h, want 0 00000000", n_done, rq_dout);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        rbase = 32'h77;
        exp_push(3, 1'b0, 32'h77);
        service(4'b1000, 1, 8, 1, 1'b1, 0);
        exp_push(1, 1'b0, 32'h0);
        service(4'b0010, 1, 5, 1, 1'b0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        cyc++;
        tests_run++;
        if ({mem_req, mem_rnw, mem_addr, mem_din, mem_be, rq_done, rq_err, rq_dout} !== '0) begin
            fails++;
            $display("FAIL reset_wait_outputs: rnw=%b addr=%h din=%h be=%h dout=%h, want all 0",
                     mem_rnw, mem_addr, mem_din, mem_be, rq_dout);
        end
        reset_n = 1'b1;
        exp_done.delete();
        mem_ready = 1'b1;
        @(negedge clk);
        cyc++;
        mem_ready = 1'b0;
        service(4'b0000, 1, 8, 1, 1'b0, 0);
        tests_run++;
        if (n_done != 0 || n_req != 0) begin
            fails++;
            $display("FAIL reset_wait_done: done=%0d req=%0d, want 0 0", n_done, n_req);
        end
    endtask

    task automatic test_regrant0();
        do_reset();
        rbase = 32'h400;
        exp_push(0, 1'b0, 32'h400);
        exp_push(0, 1'b0, 32'h401);
        service(4'b0001, 2, 20, 1, 1'b1, 0);
        tests_run++;
        if (n_done != 2 || exp_req.size() != 0) begin
            fails++;
            $display("FAIL regrant0: done=%0d left=%0d, want 2 0", n_done, exp_req.size());
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rq_req    = '0;
        mem_ready = 1'b0;
        mem_dout  = '0;
        rbase     = '0;
        n_resp    = 0;
        for (int i = 0; i < N; i++) begin
            rq_rnw[i]  = 1'b1;
            rq_addr[i] = 27'h0200000 + 27'(i * 16);
            rq_din[i]  = 32'hC0DE0000 + 32'(i);
            rq_be[i]   = 4'h3;
        end
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_starvation();
        test_timeout();
        test_reset_in_wait();
        test_regrant0();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sdram_ch1_arbiter.md
Name: sdram_ch1_arbiter

Overview:
- Shares the SDRAM controller's 32-bit byte-enabled channel 1 among NUM_REQ requesters, for example CPU, RSP DMA, RDP and PI.
- Requester 0 has priority. The remaining requesters are served round-robin, and a starvation cap guarantees they are eventually served.
- Exactly one transaction is outstanding downstream at a time.
- A watchdog terminates any transaction that never completes.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- MAX_CONSEC, 4: maximum consecutive requester-0 grants while any other requester is pending.
- TIMEOUT, 1023: cycles allowed in WAIT before forced completion; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, ~100 MHz.
- reset_n  in  1  synchronous, active-low reset.
- rq_req  in  NUM_REQ  one-cycle request pulse per requester.
- rq_rnw  in  NUM_REQ  1 = read, 0 = write.
- rq_addr  in  NUM_REQ x 27  byte address; bit 26 selects the chip.
- rq_din  in  NUM_REQ x 32  write data.
- rq_be  in  NUM_REQ x 4  byte enables, used for writes only.
- rq_done  out  NUM_REQ  one-cycle completion pulse.
- rq_err  out  1  valid with rq_done; 1 = timeout.
- rq_dout  out  32  read data, valid with rq_done; shared by all requesters.
- mem_req  out  1  one-cycle request pulse to channel 1.
- mem_rnw  out  1  direction to channel 1.
- mem_addr  out  27  address to channel 1.
- mem_din  out  32  write data to channel 1.
- mem_be  out  4  byte enables to channel 1.
- mem_ready  in  1  completion pulse from channel 1.
- mem_dout  in  32  read data from channel 1, valid with mem_ready.

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, pending=0, rr_ptr=1, consec=0, state=IDLE.
- Reset mid-transaction:
  - The transaction is abandoned and no rq_done is produced.
  - The arbiter ignores any mem_ready that arrives after reset until it issues its next mem_req.
- Requester contract: rq_rnw, rq_addr, rq_din and rq_be are held stable from the rq_req pulse until the matching rq_done.
- Pending latch:
  - pending[i] is set by rq_req[i].
  - pending[i] is cleared on the cycle requester i is granted.
  - If rq_req[i] and the grant of i coincide, pending[i] stays set; this is a new request.
  - A second rq_req[i] while pending[i] is already set is absorbed. It is a requester protocol error and is not counted.
- State machine: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If no bit of pending is set, stay in IDLE.
  - Otherwise choose grant g:
    - g = 0 if pending[0], unless consec == MAX_CONSEC and some pending[j] with j != 0 is set.
    - Else g = the first set pending[j], j in 1..NUM_REQ-1, searching cyclically from rr_ptr.
  - On the grant edge register mem_rnw, mem_addr, mem_din and mem_be from requester g, and set mem_req=1 for exactly one cycle.
  - When rnw=1, register mem_be as 4'b1111.
  - Go to WAIT and clear the timeout counter.
- consec update:
  - consec increments when g = 0 and another request is pending, saturating at MAX_CONSEC.
  - consec resets to 0 when g != 0, or when g = 0 with no other request pending.
- rr_ptr update: when g != 0, rr_ptr becomes g+1, wrapping from NUM_REQ-1 to 1.
- WAIT:
  - mem_* outputs hold their values. mem_req stays 0 after its pulse.
  - mem_ready=1: latch mem_dout into rq_dout, set err=0, go to DONE.
  - mem_ready and timeout expiry in the same cycle: mem_ready wins.
  - Counter reaches TIMEOUT: set rq_dout=0, err=1, go to DONE.
- DONE:
  - rq_done[g]=1 and rq_err=err for exactly one cycle.
  - Return to IDLE. Arbitration resumes on the next edge.
- rq_dout holds its value until the next completion.
- Latency, read, uncontended:
  - rq_req sampled at edge t.
  - mem_req high during cycle t+1..t+2.
  - rq_done high one cycle after mem_ready is sampled.
  - Minimum issue-to-issue spacing is 3 cycles plus the memory latency.
- mem_ready outside WAIT is ignored.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the widths ADDR_W=27, DATA_W=32, BE_W=4;
  - the request struct {rnw, addr, din, be}.
- Sub-module rr_pick: combinational cyclic first-set search over the pending vector starting at rr_ptr, excluding bit 0. It outputs the index and a valid flag.

Test Plan:
- Single read: rq_req[2], addr=27'h0001000, mem_ready 6 cycles after mem_req, mem_dout=32'hDEADBEEF.
  - Expect mem_req 1 cycle after rq_req with mem_addr=27'h0001000 and mem_be=4'hF.
  - Expect rq_done[2] 1 cycle after mem_ready with rq_dout=32'hDEADBEEF and rq_err=0.
- Write passthrough: rq_req[1], rnw=0, din=32'h12345678, be=4'b0011.
  - Expect mem_din=32'h12345678 and mem_be=4'b0011.
  - Expect rq_done[1] after mem_ready.
- Round-robin: pulse rq_req[1], rq_req[2] and rq_req[3] in the same cycle.
  - Expect grants in the order 1, 2, 3.
  - Then re-pulse rq_req[1] and rq_req[3]; expect order 1, 3 (rr_ptr wraps to 1 after serving 3).
- Starvation cap: requester 0 re-requests on every rq_done while pending[3] is held.
  - Expect exactly 4 grants to 0, then 1 grant to 3, then 0 again.
- Timeout: TIMEOUT=15, mem_ready never asserted.
  - Expect rq_done with rq_err=1 and rq_dout=0 after 16 WAIT cycles.
  - A late mem_ready in IDLE produces no rq_done.
- Edge cases:
  - Reset asserted in WAIT: all outputs return to 0 and no rq_done is produced.
  - rq_req[0] on the grant edge of requester 0: pending[0] stays set and requester 0 is served again afterwards.
